// File: rtl/and4_bist_if.sv
// and4_bist_if
//   Bundle between the AND4 BIST sequencer, its lab controller and the gate
//   under test (GUT).
//   Signals:
//     start             lab -> ctrl  begin a sweep (honoured in IDLE/DONE only)
//     gut_f             GUT -> ctrl  output f of the gate under test
//     gut_in            ctrl -> GUT  vector {d,c,b,a}, a = bit0
//     busy              ctrl -> lab  sweep in progress
//     done              ctrl -> lab  sweep finished, results valid
//     pass              ctrl -> lab  done with zero mismatches
//     err_count         ctrl -> lab  mismatches in this sweep, 0..16
//     first_fail_valid  ctrl -> lab  at least one mismatch seen
//     first_fail_vec    ctrl -> lab  vector of the first mismatch, 0 if none
//   Modports: master = lab controller + GUT side, slave = BIST sequencer.
interface and4_bist_if;
    logic       start;
    logic       gut_f;
    logic [3:0] gut_in;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] err_count;
    logic       first_fail_valid;
    logic [3:0] first_fail_vec;

    modport master (
        output start,
        output gut_f,
        input  gut_in,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  first_fail_valid,
        input  first_fail_vec
    );

    modport slave (
        input  start,
        input  gut_f,
        output gut_in,
        output busy,
        output done,
        output pass,
        output err_count,
        output first_fail_valid,
        output first_fail_vec
    );
endinterface

// File: rtl/and4_bist_ctrl.sv
// and4_bist_ctrl
//   Self-test sequencer for a single 4-input AND gate. On start it walks all
//   16 input vectors in binary order, holds each one for SETTLE_CYCLES
//   cycles, samples the gate output for one more cycle and compares it with
//   the AND of the vector. Reports pass/fail, a mismatch count and the first
//   failing vector.
//   Parameters:
//     SETTLE_CYCLES  cycles each vector is held before sampling (1..15)
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous reset, active low
//     bus    and4_bist_if.slave (start/gut_f in, gut_in and results out)
module and4_bist_ctrl #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    and4_bist_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] vec_q, vec_d;
    logic [3:0] settle_cnt_q, settle_cnt_d;
    logic [4:0] err_count_q, err_count_d;
    logic       first_fail_valid_q, first_fail_valid_d;
    logic [3:0] first_fail_vec_q, first_fail_vec_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q            <= S_IDLE;
            vec_q              <= 4'd0;
            settle_cnt_q       <= 4'd0;
            err_count_q        <= 5'd0;
            first_fail_valid_q <= 1'b0;
            first_fail_vec_q   <= 4'd0;
        end else begin
            state_q            <= state_d;
            vec_q              <= vec_d;
            settle_cnt_q       <= settle_cnt_d;
            err_count_q        <= err_count_d;
            first_fail_valid_q <= first_fail_valid_d;
            first_fail_vec_q   <= first_fail_vec_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        vec_d              = vec_q;
        settle_cnt_d       = settle_cnt_q;
        err_count_d        = err_count_q;
        first_fail_valid_d = first_fail_valid_q;
        first_fail_vec_d   = first_fail_vec_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d            = S_DRIVE;
                    vec_d              = 4'd0;
                    settle_cnt_d       = 4'd0;
                    err_count_d        = 5'd0;
                    first_fail_valid_d = 1'b0;
                    first_fail_vec_d   = 4'd0;
                end
            end
            S_DRIVE: begin
                settle_cnt_d = settle_cnt_q + 4'd1;
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (bus.gut_f != (&vec_q)) begin
                    err_count_d = err_count_q + 5'd1;
                    if (!first_fail_valid_q) begin
                        first_fail_valid_d = 1'b1;
                        first_fail_vec_d   = vec_q;
                    end
                end
                // Last vector ends the sweep; vec stays at 15 so the GUT
                // keeps seeing the final vector while results are read.
                if (vec_q == 4'hF) begin
                    state_d = S_DONE;
                end else begin
                    vec_d        = vec_q + 4'd1;
                    settle_cnt_d = 4'd0;
                    state_d      = S_DRIVE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // gut_in is the vector register itself: 0 after reset, current vector
    // throughout DRIVE/SAMPLE, 4'hF once a sweep has finished.
    assign bus.gut_in           = vec_q;
    assign bus.busy             = (state_q == S_DRIVE) || (state_q == S_SAMPLE);
    assign bus.done             = (state_q == S_DONE);
    assign bus.pass             = (state_q == S_DONE) && (err_count_q == 5'd0);
    assign bus.err_count        = err_count_q;
    assign bus.first_fail_valid = first_fail_valid_q;
    assign bus.first_fail_vec   = first_fail_vec_q;

endmodule
